sm3_ahb_dma: RTL and testbench
==============================

Name: sm3_ahb_dma

Overview:
- AHB-Lite initiator for the SM3 accelerator. It is the master-side counterpart of the REG slave register file.
- On START it fetches BSR message words from system memory at SAR_ADDR and streams them to the SM3 core.
- When the core reports the 256-bit result, it writes the result as 8 words to DAR_ADDR, then raises a completion interrupt.

Parameters:
- BASE_ADDR, 32'h2000_0000, byte base of the memory window that SAR_ADDR and DAR_ADDR index.
- ADDR_W, 13, width of the word-address and word-count inputs.

Ports:
- AHB_HCLK  in  1  single clock; all logic rising-edge.
- AHB_HRESETN  in  1  reset, synchronous, active-low.
- START  in  1  one-cycle start pulse; ignored unless FSM is IDLE.
- SAR_ADDR  in  13  source word address (sampled at START).
- DAR_ADDR  in  13  destination word address (sampled at START).
- BSR  in  13  message length in 32-bit words (sampled at START).
- LAST_RES  in  256  hash result from core.
- RES_VALID  in  1  LAST_RES valid (level).
- MSG_DATA  out  32  message word to core.
- MSG_VALID  out  1  MSG_DATA valid.
- MSG_LAST  out  1  marks final message word.
- MSG_READY  in  1  core accepts word when MSG_VALID&MSG_READY.
- M_HADDR  out  32  AHB address.
- M_HTRANS  out  2  IDLE=00, NONSEQ=10 only.
- M_HWRITE  out  1  transfer direction.
- M_HSIZE  out  3  constant 3'b010 (word).
- M_HWDATA  out  32  write data (data phase).
- M_HRDATA  in  32  read data.
- M_HREADY  in  1  transfer ready.
- M_HRESP  in  1  0=OKAY, 1=ERROR.
- DONE_INTR  out  1  one-cycle completion pulse.
- ERR_INTR  out  1  sticky bus-error flag.

Behaviour:
- Reset is checked synchronously, as in the codebase. When AHB_HRESETN=0 at an edge:
  - FSM goes to IDLE.
  - M_HTRANS=00, M_HWRITE=0, M_HADDR=0, M_HWDATA=0.
  - MSG_VALID=0, MSG_LAST=0, MSG_DATA=0.
  - DONE_INTR=0, ERR_INTR=0.
  - Reset mid-transfer abandons the transfer with no completion.
- Address generation: M_HADDR = BASE_ADDR + {word_addr, 2'b00}. word_addr = base + offset, computed modulo 2^13 (wraps; no carry into BASE_ADDR).
- Transfers: single, non-overlapped NONSEQ transfers. The address phase and data phase of consecutive transfers never overlap.
- FSM states:
  - IDLE: on START, latch SAR/DAR/BSR, clear ERR_INTR and cnt. If BSR==0, go to WAIT_HASH; else go to RD_ADDR.
  - RD_ADDR: when the output buffer is empty (MSG_VALID=0, or a handshake this cycle), drive HTRANS=NONSEQ, HWRITE=0, HADDR=SAR+cnt. Otherwise drive HTRANS=IDLE. On a NONSEQ cycle with HREADY=1, go to RD_DATA.
  - RD_DATA: wait HREADY=1.
    - On HRESP=ERROR, go to ERR.
    - On OKAY, register M_HRDATA into MSG_DATA, set MSG_VALID=1, cnt++. Set MSG_LAST=1 when cnt+1==BSR and go to WAIT_HASH; else go to RD_ADDR.
  - WAIT_HASH: wait MSG_VALID==0 && RES_VALID==1. Then latch LAST_RES, set idx=0, go to WR_ADDR.
  - WR_ADDR: drive HTRANS=NONSEQ, HWRITE=1, HADDR=DAR+idx. On HREADY, go to WR_DATA.
  - WR_DATA: drive HWDATA = result word idx, where word 0 = bits[255:224] and word 7 = bits[31:0]. Hold HWDATA until HREADY.
    - On ERROR, go to ERR.
    - On OKAY with idx==7, go to DONE; otherwise idx++ and go to WR_ADDR.
  - DONE: DONE_INTR=1 for exactly one cycle, then IDLE.
  - ERR: ERR_INTR=1, HTRANS=IDLE, drop MSG_VALID/MSG_LAST, go to IDLE. ERR_INTR stays set until the next accepted START or reset.
- Stream: MSG_VALID holds until the MSG_READY handshake; MSG_DATA and MSG_LAST are stable while valid. MSG_LAST clears on its handshake.
- START while not IDLE: ignored, no state change.
- RES_VALID asserted before the final message word is consumed: it is held off by WAIT_HASH. Never sample LAST_RES early.
- Latency:
  - START to first NONSEQ: 1 cycle.
  - Per read word: at least 2 cycles plus HREADY wait states.
  - Result write: 16 cycles with zero wait states.

Decomposition:
- Shared package sm3_pkg holds:
  - HTRANS_IDLE/HTRANS_NONSEQ.
  - HSIZE_WORD.
  - HRESP_OKAY/HRESP_ERROR.
  - FSM state encoding.
  - RES_WORDS=8.
- One natural sub-module: sm3_dma_addr_gen, which produces M_HADDR from base, offset and BASE_ADDR with 13-bit wrap. Everything else stays in the top level.

Test Plan:
- Read phase: SAR=0x010, BSR=3, memory words 0x11111111/0x22222222/0x33333333, zero waits, MSG_READY=1.
  - HADDR must be 0x20000040, 0x20000044, 0x20000048.
  - MSG_DATA must appear in that order, with MSG_LAST only on 0x33333333.
- Write phase: LAST_RES = 00000000_11111111_…_77777777 with RES_VALID=1, DAR=0x020.
  - Eight writes to 0x20000080..0x2000009C with HWDATA 00000000..77777777.
  - DONE_INTR high exactly one cycle.
- Stalls: HREADY low 3 cycles in every data phase, plus MSG_READY low 5 cycles.
  - No lost or duplicated words.
  - HWDATA and MSG_DATA stable during stalls.
  - Second read not issued while MSG_VALID=1.
- Wrap: SAR=0x1FFF, BSR=2 → addresses 0x20007FFC then 0x20000000.
  - BSR=0 → no reads, straight to result writes.
- Error: HRESP=ERROR on 2nd read → ERR_INTR=1, HTRANS=00, MSG_VALID=0, FSM IDLE.
  - Next START clears ERR_INTR.
- Reset and busy START: AHB_HRESETN=0 for one edge during WR_DATA idx=4 → all outputs reset next cycle, no DONE_INTR.
  - START pulsed mid-read → ignored.

Source files
------------

// File: rtl/sm3_pkg.sv
// Shared definitions for the SM3 accelerator AHB-Lite DMA initiator.
package sm3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned RES_WORDS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WAIT_HASH,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_DONE,
    ST_ERR
  } dma_state_e;

  // Result word idx of the 256-bit digest; word 0 is the most significant.
  function automatic logic [31:0] res_word(input logic [255:0] res, input logic [2:0] idx);
    logic [7:0] lsb;
    lsb = {3'd7 - idx, 5'd0};
    return res[lsb +: 32];
  endfunction

endpackage

// File: rtl/sm3_dma_addr_gen.sv
// Word address to AHB byte address: (base + offset) wraps inside the window.
module sm3_dma_addr_gen #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned ADDR_W    = 13
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  output logic [31:0]       haddr
);

  logic [ADDR_W-1:0] word_addr;

  // Sum kept at ADDR_W bits so it never carries into the window base.
  always_comb begin
    word_addr = base + offset;
    haddr     = BASE_ADDR + {{(30 - ADDR_W){1'b0}}, word_addr, 2'b00};
  end

endmodule

// File: rtl/sm3_ahb_dma.sv
// AHB-Lite initiator: streams message words to the SM3 core, writes back the digest.
module sm3_ahb_dma
  import sm3_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned ADDR_W    = 13
) (
  input  logic              AHB_HCLK,
  input  logic              AHB_HRESETN,
  input  logic              START,
  input  logic [ADDR_W-1:0] SAR_ADDR,
  input  logic [ADDR_W-1:0] DAR_ADDR,
  input  logic [ADDR_W-1:0] BSR,
  input  logic [255:0]      LAST_RES,
  input  logic              RES_VALID,
  output logic [31:0]       MSG_DATA,
  output logic              MSG_VALID,
  output logic              MSG_LAST,
  input  logic              MSG_READY,
  output logic [31:0]       M_HADDR,
  output logic [1:0]        M_HTRANS,
  output logic              M_HWRITE,
  output logic [2:0]        M_HSIZE,
  output logic [31:0]       M_HWDATA,
  input  logic [31:0]       M_HRDATA,
  input  logic              M_HREADY,
  input  logic              M_HRESP,
  output logic              DONE_INTR,
  output logic              ERR_INTR
);

  dma_state_e        state;
  logic [ADDR_W-1:0] sar_q;
  logic [ADDR_W-1:0] dar_q;
  logic [ADDR_W-1:0] bsr_q;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_inc;
  logic [2:0]        idx;
  logic [2:0]        idx_inc;
  logic [255:0]      res_q;
  logic [ADDR_W-1:0] ag_base;
  logic [ADDR_W-1:0] ag_off;
  logic [31:0]       ag_haddr;

  assign M_HSIZE = HSIZE_WORD;
  assign cnt_inc = cnt + ADDR_W'(1);
  assign idx_inc = idx + 3'd1;

  // Select the address the next registered NONSEQ will carry.
  always_comb begin
    ag_base = sar_q;
    ag_off  = '0;
    case (state)
      ST_IDLE:      ag_base = SAR_ADDR;
      ST_RD_ADDR:   begin ag_base = sar_q; ag_off = cnt; end
      ST_WAIT_HASH: ag_base = dar_q;
      ST_WR_DATA:   begin ag_base = dar_q; ag_off = ADDR_W'(idx_inc); end
      default:      ;
    endcase
  end

  sm3_dma_addr_gen #(
    .BASE_ADDR (BASE_ADDR),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .base   (ag_base),
    .offset (ag_off),
    .haddr  (ag_haddr)
  );

  // Transfer FSM with all bus, stream and interrupt outputs registered.
  always_ff @(posedge AHB_HCLK) begin
    if (!AHB_HRESETN) begin
      state     <= ST_IDLE;
      sar_q     <= '0;
      dar_q     <= '0;
      bsr_q     <= '0;
      cnt       <= '0;
      idx       <= '0;
      res_q     <= '0;
      M_HTRANS  <= HTRANS_IDLE;
      M_HWRITE  <= 1'b0;
      M_HADDR   <= '0;
      M_HWDATA  <= '0;
      MSG_DATA  <= '0;
      MSG_VALID <= 1'b0;
      MSG_LAST  <= 1'b0;
      DONE_INTR <= 1'b0;
      ERR_INTR  <= 1'b0;
    end else begin
      DONE_INTR <= 1'b0;
      if (MSG_VALID && MSG_READY) begin
        MSG_VALID <= 1'b0;
        MSG_LAST  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (START) begin
            sar_q    <= SAR_ADDR;
            dar_q    <= DAR_ADDR;
            bsr_q    <= BSR;
            cnt      <= '0;
            ERR_INTR <= 1'b0;
            if (BSR == '0) begin
              state <= ST_WAIT_HASH;
            end else begin
              state    <= ST_RD_ADDR;
              M_HTRANS <= HTRANS_NONSEQ;
              M_HWRITE <= 1'b0;
              M_HADDR  <= ag_haddr;
            end
          end
        end
        // NONSEQ is raised only once the buffer is known to be empty next
        // cycle, so a read is never in flight while MSG_VALID is high.
        ST_RD_ADDR: begin
          if (M_HTRANS == HTRANS_NONSEQ) begin
            if (M_HREADY) begin
              M_HTRANS <= HTRANS_IDLE;
              state    <= ST_RD_DATA;
            end
          end else if (!MSG_VALID || MSG_READY) begin
            M_HTRANS <= HTRANS_NONSEQ;
            M_HWRITE <= 1'b0;
            M_HADDR  <= ag_haddr;
          end
        end
        ST_RD_DATA: begin
          if (M_HREADY) begin
            if (M_HRESP == HRESP_OKAY) begin
              MSG_DATA  <= M_HRDATA;
              MSG_VALID <= 1'b1;
              cnt       <= cnt_inc;
              if (cnt_inc == bsr_q) begin
                MSG_LAST <= 1'b1;
                state    <= ST_WAIT_HASH;
              end else begin
                state <= ST_RD_ADDR;
              end
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_WAIT_HASH: begin
          if (!MSG_VALID && RES_VALID) begin
            res_q    <= LAST_RES;
            idx      <= '0;
            state    <= ST_WR_ADDR;
            M_HTRANS <= HTRANS_NONSEQ;
            M_HWRITE <= 1'b1;
            M_HADDR  <= ag_haddr;
          end
        end
        ST_WR_ADDR: begin
          if (M_HREADY) begin
            M_HTRANS <= HTRANS_IDLE;
            M_HWDATA <= res_word(res_q, idx);
            state    <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (M_HREADY) begin
            if (M_HRESP == HRESP_ERROR) begin
              state <= ST_ERR;
            end else if (idx == 3'(RES_WORDS - 1)) begin
              DONE_INTR <= 1'b1;
              M_HWRITE  <= 1'b0;
              state     <= ST_DONE;
            end else begin
              idx      <= idx_inc;
              M_HTRANS <= HTRANS_NONSEQ;
              M_HADDR  <= ag_haddr;
              state    <= ST_WR_ADDR;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_ERR: begin
          ERR_INTR  <= 1'b1;
          M_HTRANS  <= HTRANS_IDLE;
          M_HWRITE  <= 1'b0;
          MSG_VALID <= 1'b0;
          MSG_LAST  <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_ahb_dma.sv
// Scoreboard bench for sm3_ahb_dma with a behavioural AHB memory slave.
module tb_sm3_ahb_dma;

  typedef struct { logic [31:0] d; logic l; } msg_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  logic         clk;
  logic         HRESETN;
  logic         START;
  logic [12:0]  SAR_ADDR, DAR_ADDR, BSR;
  logic [255:0] LAST_RES;
  logic         RES_VALID;
  logic [31:0]  MSG_DATA;
  logic         MSG_VALID, MSG_LAST, MSG_READY;
  logic [31:0]  M_HADDR;
  logic [1:0]   M_HTRANS;
  logic         M_HWRITE;
  logic [2:0]   M_HSIZE;
  logic [31:0]  M_HWDATA, M_HRDATA;
  logic         M_HREADY, M_HRESP;
  logic         DONE_INTR, ERR_INTR;

  sm3_ahb_dma #(.BASE_ADDR(32'h2000_0000), .ADDR_W(13)) dut (
    .AHB_HCLK(clk), .AHB_HRESETN(HRESETN), .START(START),
    .SAR_ADDR(SAR_ADDR), .DAR_ADDR(DAR_ADDR), .BSR(BSR),
    .LAST_RES(LAST_RES), .RES_VALID(RES_VALID),
    .MSG_DATA(MSG_DATA), .MSG_VALID(MSG_VALID), .MSG_LAST(MSG_LAST), .MSG_READY(MSG_READY),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP),
    .DONE_INTR(DONE_INTR), .ERR_INTR(ERR_INTR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  msg_t        exp_msg[$];
  logic [31:0] exp_ra[$];
  wr_t         exp_wr[$];
  int          done_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AHB memory slave (updates on the falling edge) -----------
  logic [31:0] mem [0:8191];
  bit          dphase = 0, dp_write = 0, ap_pending = 0, ap_write = 0;
  logic [31:0] dp_addr = '0, ap_addr = '0;
  int          waits = 0, wait_left = 0, read_cnt = 0, err_read_idx = 0, wr_started = 0;
  bit          stall_mode = 0;
  int          rdy_cnt = 0;

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'h2000_0000) >> 2;
    return int'(off[12:0]);
  endfunction

  always @(negedge clk) begin
    if (!HRESETN) begin
      dphase = 0; ap_pending = 0;
      M_HREADY = 1'b1; M_HRESP = 1'b0; M_HRDATA = '0;
    end else begin
      if (dphase && M_HREADY) dphase = 0;
      if (ap_pending && M_HREADY) begin
        dphase = 1; dp_addr = ap_addr; dp_write = ap_write; wait_left = waits;
        if (ap_write) wr_started++; else read_cnt++;
      end
      ap_pending = (M_HTRANS == 2'b10);
      ap_addr    = M_HADDR;
      ap_write   = M_HWRITE;
      if (dphase && wait_left > 0) begin
        M_HREADY = 1'b0; wait_left--;
      end else begin
        M_HREADY = 1'b1;
      end
      M_HRDATA = (dphase && !dp_write) ? mem[widx(dp_addr)] : 32'h0;
      M_HRESP  = dphase && !dp_write && M_HREADY && err_read_idx != 0 && read_cnt == err_read_idx;
    end
    if (stall_mode) begin
      rdy_cnt   = (rdy_cnt + 1) % 6;
      MSG_READY = (rdy_cnt == 5);
    end else begin
      MSG_READY = 1'b1;
    end
  end

  // ---------------- Monitor: pops the scoreboard on every DUT event ---------
  always begin
    @(negedge clk); #2;
    if (HRESETN) begin
      if (MSG_VALID) begin
        if (exp_msg.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL msg_unexpected: got word %h, expected none", MSG_DATA);
        end else if (MSG_READY) begin
          msg_t m;
          m = exp_msg.pop_front();
          chk("msg_data", MSG_DATA, m.d);
          chk("msg_last", MSG_LAST, m.l);
        end else begin
          chk("msg_hold", MSG_DATA, exp_msg[0].d);
        end
      end
      if (M_HTRANS == 2'b10 && M_HREADY) begin
        if (!M_HWRITE) begin
          chk("rd_while_valid", MSG_VALID, 0);
          if (exp_ra.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL rd_unexpected: got read at %h, expected none", M_HADDR);
          end else begin
            chk("rd_addr", M_HADDR, exp_ra.pop_front());
          end
        end else begin
          chk("wr_before_msgs_done", exp_msg.size(), 0);
        end
      end
      if (dphase && dp_write) begin
        if (exp_wr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL wr_unexpected: got write at %h, expected none", dp_addr);
        end else if (M_HREADY) begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", dp_addr, w.a);
          chk("wr_data", M_HWDATA, w.d);
        end else begin
          chk("wr_hold", M_HWDATA, exp_wr[0].d);
        end
      end
      if (DONE_INTR) done_cycles++;
    end
  end

  // ---------------- Stimulus helpers ----------------------------------------
  task automatic step();
    @(negedge clk); #2;
  endtask

  task automatic push_writes(input logic [12:0] dar);
    for (int unsigned i = 0; i < 8; i++) begin
      wr_t w;
      logic [12:0] wa;
      wa  = dar + 13'(i);
      w.a = 32'h2000_0000 + {17'd0, wa, 2'b00};
      w.d = 32'h1111_1111 * i;
      exp_wr.push_back(w);
    end
  endtask

  task automatic push_msg(input logic [31:0] d, input logic l);
    msg_t m;
    m.d = d; m.l = l;
    exp_msg.push_back(m);
  endtask

  task automatic start_dma(input logic [12:0] sar, input logic [12:0] dar, input logic [12:0] bsr);
    step();
    SAR_ADDR = sar; DAR_ADDR = dar; BSR = bsr; START = 1'b1;
    step();
    START = 1'b0;
    if (bsr != 0) chk("start_to_nonseq", M_HTRANS, 2'b10);
  endtask

  task automatic wait_done(input int budget, input int d0);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (DONE_INTR) seen = 1;
    end
    chk("done_seen", seen, 1);
    repeat (3) step();
    chk("done_width", done_cycles - d0, 1);
    chk("queues_drained", exp_ra.size() + exp_msg.size() + exp_wr.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_htrans"}, M_HTRANS, 0);
    chk({tag, "_hwrite"}, M_HWRITE, 0);
    chk({tag, "_haddr"}, M_HADDR, 0);
    chk({tag, "_hwdata"}, M_HWDATA, 0);
    chk({tag, "_msg_valid"}, MSG_VALID, 0);
    chk({tag, "_msg_last"}, MSG_LAST, 0);
    chk({tag, "_msg_data"}, MSG_DATA, 0);
    chk({tag, "_done"}, DONE_INTR, 0);
    chk({tag, "_err"}, ERR_INTR, 0);
  endtask

  // ---------------- Directed tests ------------------------------------------
  initial begin
    int d0;
    bit hit;
    logic [255:0] res;
    HRESETN = 1'b0; START = 1'b0; SAR_ADDR = '0; DAR_ADDR = '0; BSR = '0;
    LAST_RES = '0; RES_VALID = 1'b0;
    M_HREADY = 1'b1; M_HRESP = 1'b0; M_HRDATA = '0; MSG_READY = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    chk("hsize", M_HSIZE, 3'b010);
    HRESETN = 1'b1;
    step();

    mem[16] = 32'h1111_1111; mem[17] = 32'h2222_2222; mem[18] = 32'h3333_3333;
    mem[256] = 32'hA000_0001; mem[257] = 32'hA000_0002;
    mem[258] = 32'hA000_0003; mem[259] = 32'hA000_0004;
    mem[8191] = 32'hCAFE_F00D; mem[0] = 32'h0BAD_BEEF;
    mem[512] = 32'h5A5A_5A5A; mem[513] = 32'hDEAD_0001; mem[514] = 32'hDEAD_0002;
    for (int unsigned i = 0; i < 8; i++) res[255 - 32*i -: 32] = 32'h1111_1111 * i;
    LAST_RES = res;
    RES_VALID = 1'b1;

    // Basic read + write, result already valid before the stream finishes
    exp_ra.push_back(32'h2000_0040); exp_ra.push_back(32'h2000_0044); exp_ra.push_back(32'h2000_0048);
    push_msg(32'h1111_1111, 0); push_msg(32'h2222_2222, 0); push_msg(32'h3333_3333, 1);
    push_writes(13'h020);
    d0 = done_cycles;
    start_dma(13'h010, 13'h020, 13'd3);
    wait_done(200, d0);

    // Wait states on every data phase, consumer stalls, START while busy
    waits = 3; stall_mode = 1;
    exp_ra.push_back(32'h2000_0400); exp_ra.push_back(32'h2000_0404);
    exp_ra.push_back(32'h2000_0408); exp_ra.push_back(32'h2000_040C);
    push_msg(32'hA000_0001, 0); push_msg(32'hA000_0002, 0);
    push_msg(32'hA000_0003, 0); push_msg(32'hA000_0004, 1);
    push_writes(13'h040);
    d0 = done_cycles;
    start_dma(13'h100, 13'h040, 13'd4);
    repeat (8) step();
    SAR_ADDR = 13'h700; DAR_ADDR = 13'h700; BSR = 13'd1; START = 1'b1;
    step();
    START = 1'b0;
    wait_done(600, d0);
    waits = 0; stall_mode = 0;

    // Address wrap on both source and destination
    exp_ra.push_back(32'h2000_7FFC); exp_ra.push_back(32'h2000_0000);
    push_msg(32'hCAFE_F00D, 0); push_msg(32'h0BAD_BEEF, 1);
    push_writes(13'h1FFC);
    d0 = done_cycles;
    start_dma(13'h1FFF, 13'h1FFC, 13'd2);
    wait_done(200, d0);

    // Empty message: straight to result writes
    push_writes(13'h030);
    d0 = done_cycles;
    start_dma(13'h010, 13'h030, 13'd0);
    wait_done(200, d0);

    // Bus error on the second read
    err_read_idx = 2; read_cnt = 0;
    exp_ra.push_back(32'h2000_0800); exp_ra.push_back(32'h2000_0804);
    push_msg(32'h5A5A_5A5A, 0);
    d0 = done_cycles;
    start_dma(13'h200, 13'h020, 13'd3);
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      step();
      if (ERR_INTR) hit = 1;
    end
    chk("err_seen", hit, 1);
    chk("err_htrans", M_HTRANS, 0);
    chk("err_msg_valid", MSG_VALID, 0);
    chk("err_msg_last", MSG_LAST, 0);
    repeat (4) step();
    chk("err_sticky", ERR_INTR, 1);
    chk("err_no_done", done_cycles - d0, 0);
    chk("err_queues", exp_ra.size() + exp_msg.size() + exp_wr.size(), 0);
    err_read_idx = 0;

    // Next START clears the error; reset lands during the fifth write
    waits = 3; wr_started = 0;
    exp_ra.push_back(32'h2000_0040);
    push_msg(32'h1111_1111, 1);
    push_writes(13'h020);
    d0 = done_cycles;
    start_dma(13'h010, 13'h020, 13'd1);
    chk("err_cleared", ERR_INTR, 0);
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      step();
      if (wr_started == 5 && dphase && dp_write && !M_HREADY) hit = 1;
    end
    chk("reached_wr_idx4", hit, 1);
    HRESETN = 1'b0;
    step();
    HRESETN = 1'b1;
    check_reset_outputs("midreset");
    chk("writes_before_reset", exp_wr.size(), 4);
    exp_wr.delete(); exp_msg.delete(); exp_ra.delete();
    waits = 0;
    repeat (20) step();
    chk("no_done_after_reset", done_cycles - d0, 0);
    chk("idle_after_reset", M_HTRANS, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
